// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: register map,
// STATUS/CTRL bit positions, FSM state type and small helpers.
package ps2_host_tx_pkg;

  localparam logic [1:0] PS2TX_TXDATA = 2'd0;
  localparam logic [1:0] PS2TX_STATUS = 2'd1;
  localparam logic [1:0] PS2TX_CTRL   = 2'd2;

  localparam int unsigned PS2TX_ST_BUSY    = 0;
  localparam int unsigned PS2TX_ST_DONE    = 1;
  localparam int unsigned PS2TX_ST_NACK    = 2;
  localparam int unsigned PS2TX_ST_TIMEOUT = 3;

  localparam int unsigned PS2TX_CTRL_IRQ_EN = 0;
  localparam int unsigned PS2TX_CTRL_CLEAR  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_BITS,
    ST_ACK,
    ST_WAIT_IDLE
  } tx_state_t;

  // Width of a counter that must hold 0..limit-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe
// taken from a third register stage.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a fake edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with MMIO register interface; drives the
// open-drain clock/data lines through active-high pull-low enables.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ     = 62500000,
  parameter int unsigned INHIBIT_CYCLES = CLOCK_FREQ / 10000,
  parameter int unsigned TIMEOUT_CYCLES = CLOCK_FREQ / 1000 * 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       IDX_ACK  = 4'd10;

  tx_state_t        state, state_next;
  logic [INH_W-1:0] inh_cnt, inh_cnt_next;
  logic [TO_W-1:0]  to_cnt, to_cnt_next;
  logic [3:0]       bit_idx, bit_idx_next;
  logic [9:0]       tx_frame;
  logic             clk_oe_next, data_oe_next;

  logic done, err_nack, err_timeout, irq_en;
  logic set_done, set_nack, set_to;

  logic clk_s, clk_fall, data_s, data_fall_unused;
  logic start_tx, ctrl_wr, busy;
  logic unused_d;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (ps2_clk_i),
    .level (clk_s),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (ps2_data_i),
    .level (data_s),
    .fall  (data_fall_unused)
  );

  assign busy     = (state != ST_IDLE);
  assign start_tx = we && (a == PS2TX_TXDATA) && !busy;
  assign ctrl_wr  = we && (a == PS2TX_CTRL);
  assign unused_d = ^d[31:8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_idx     <= '0;
      tx_frame    <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_next;
      inh_cnt     <= inh_cnt_next;
      to_cnt      <= to_cnt_next;
      bit_idx     <= bit_idx_next;
      ps2_clk_oe  <= clk_oe_next;
      ps2_data_oe <= data_oe_next;
      if (start_tx) begin
        tx_frame <= {1'b1, odd_parity(d[7:0]), d[7:0]};
      end
    end
  end

  // Line enables are registered from the next-state values so they change on
  // the same edge as the state they belong to.
  always_comb begin
    state_next   = state;
    inh_cnt_next = inh_cnt;
    to_cnt_next  = to_cnt;
    bit_idx_next = bit_idx;
    clk_oe_next  = 1'b0;
    data_oe_next = 1'b0;
    set_done     = 1'b0;
    set_nack     = 1'b0;
    set_to       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start_tx) begin
          state_next   = ST_INHIBIT;
          inh_cnt_next = '0;
          clk_oe_next  = 1'b1;
          data_oe_next = (INHIBIT_CYCLES == 1);
        end
      end
      ST_INHIBIT: begin
        clk_oe_next = 1'b1;
        if (inh_cnt == INH_LAST) begin
          state_next   = ST_REQ;
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b1;
        end else begin
          inh_cnt_next = inh_cnt + 1'b1;
          data_oe_next = (inh_cnt == INH_PRE);
        end
      end
      ST_REQ: begin
        state_next   = ST_BITS;
        bit_idx_next = '0;
        to_cnt_next  = '0;
        data_oe_next = 1'b1;
      end
      ST_BITS: begin
        data_oe_next = ps2_data_oe;
        if (clk_fall) begin
          if (bit_idx == IDX_ACK) begin
            state_next   = ST_ACK;
            data_oe_next = 1'b0;
          end else begin
            data_oe_next = ~tx_frame[bit_idx];
            bit_idx_next = bit_idx + 4'd1;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          set_nack   = data_s;
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          set_done   = ~err_nack;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Timeout overrides whatever the state logic decided above.
    if (state inside {ST_BITS, ST_ACK, ST_WAIT_IDLE}) begin
      if (clk_fall) begin
        to_cnt_next = '0;
      end else if (to_cnt == TO_LAST) begin
        state_next   = ST_IDLE;
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        set_to       = 1'b1;
        set_done     = 1'b0;
        set_nack     = 1'b0;
      end else begin
        to_cnt_next = to_cnt + 1'b1;
      end
    end
  end

  // Clears come first so a same-cycle set event overrides them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done        <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
      irq_en      <= 1'b0;
    end else begin
      if (start_tx || (ctrl_wr && d[PS2TX_CTRL_CLEAR])) begin
        done        <= 1'b0;
        err_nack    <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (set_done) done        <= 1'b1;
      if (set_nack) err_nack    <= 1'b1;
      if (set_to)   err_timeout <= 1'b1;
      if (ctrl_wr)  irq_en      <= d[PS2TX_CTRL_IRQ_EN];
    end
  end

  always_comb begin
    spo = '0;
    case (a)
      PS2TX_STATUS: begin
        spo[PS2TX_ST_BUSY]    = busy;
        spo[PS2TX_ST_DONE]    = done;
        spo[PS2TX_ST_NACK]    = err_nack;
        spo[PS2TX_ST_TIMEOUT] = err_timeout;
      end
      PS2TX_CTRL: spo[PS2TX_CTRL_IRQ_EN] = irq_en;
      default:    spo = '0;
    endcase
  end

  assign irq = irq_en & (done | err_nack | err_timeout);

endmodule
